// File: rtl/dynamixel_write_scheduler.sv
// dynamixel_write_scheduler
// Shares one dynamixel_sync_write engine between three fixed write slots
// (torque enable, goal velocity, goal position). Requests are latched and
// coalesced per slot; slot 0 wins outright, slots 1 and 2 alternate.
// The engine gives no busy indication, so each packet is followed by a
// hold-off computed from its length, the UART bit period and a guard gap.
//
// state | meaning
// ------+-----------------------------------------------------------
// idle  | waiting for hold-off to expire and any slot to be pending
// issue | one-cycle launch: send/ack high, engine inputs just loaded
// wait  | counting down the packet hold-off, engine inputs held

module dynamixel_write_scheduler #(
    parameter int clocks_per_bit = 1,
    parameter int byte_guard     = 2,
    parameter int gap_cycles     = 16,
    parameter int addr0          = 64,
    parameter int len0           = 1,
    parameter int addr1          = 104,
    parameter int len1           = 4,
    parameter int addr2          = 116,
    parameter int len2           = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         req0,
    input  logic         req1,
    input  logic         req2,
    input  logic [127:0] data0,
    input  logic [127:0] data1,
    input  logic [127:0] data2,
    output logic         ack0,
    output logic         ack1,
    output logic         ack2,
    output logic         busy,
    output logic         send,
    output logic [15:0]  address,
    output logic [15:0]  data_len,
    output logic [31:0]  value1,
    output logic [31:0]  value2,
    output logic [31:0]  value3,
    output logic [31:0]  value4
);

    // Clocks spent on one byte on the wire, including the guard allowance.
    localparam int byte_clocks = 10 * clocks_per_bit + byte_guard;

    // Packet hold-offs: a four-servo sync write is 14 + 4*(1+len) bytes.
    localparam logic [23:0] hold0    = 24'((14 + 4 * (1 + len0)) * byte_clocks + gap_cycles);
    localparam logic [23:0] hold1    = 24'((14 + 4 * (1 + len1)) * byte_clocks + gap_cycles);
    localparam logic [23:0] hold2    = 24'((14 + 4 * (1 + len2)) * byte_clocks + gap_cycles);
    localparam logic [23:0] hold_max = 24'((14 + 4 * (1 + 4)) * byte_clocks + gap_cycles);

    typedef enum logic [1:0] {
        s_idle  = 2'd0,
        s_issue = 2'd1,
        s_wait  = 2'd2
    } state_t;

    state_t        state;
    logic [23:0]   holdoff;
    logic [2:0]    pend;
    logic [127:0]  buf0;
    logic [127:0]  buf1;
    logic [127:0]  buf2;
    logic          rr;
    logic [1:0]    slot;

    logic [1:0]    win;
    logic [15:0]   win_addr;
    logic [15:0]   win_len;
    logic [127:0]  win_buf;
    logic [23:0]   hold_sel;
    logic          launch;

    // A launch happens on the edge leaving idle with an expired hold-off.
    assign launch = (state == s_idle) && (holdoff == 24'd0) && (pend != 3'b000);

    assign busy = (state != s_idle) || (holdoff != 24'd0);

    // Arbitration: slot 0 absolute, slots 1/2 round-robin on rr.
    always_comb begin
        win = 2'd2;
        if (pend[0]) begin
            win = 2'd0;
        end else if (pend[1] && pend[2]) begin
            win = rr ? 2'd2 : 2'd1;
        end else if (pend[1]) begin
            win = 2'd1;
        end
    end

    // Select the winning slot's fixed address/length and latched values.
    always_comb begin
        win_addr = 16'(addr0);
        win_len  = 16'(len0);
        win_buf  = buf0;
        case (win)
            2'd1: begin
                win_addr = 16'(addr1);
                win_len  = 16'(len1);
                win_buf  = buf1;
            end
            2'd2: begin
                win_addr = 16'(addr2);
                win_len  = 16'(len2);
                win_buf  = buf2;
            end
            default: ;
        endcase
    end

    // Hold-off for the slot that was just launched.
    always_comb begin
        hold_sel = hold0;
        case (slot)
            2'd1:    hold_sel = hold1;
            2'd2:    hold_sel = hold2;
            default: hold_sel = hold0;
        endcase
    end

    // Pending latches: a request always wins over the clear of a launch,
    // so a re-request during the grant is never lost.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend <= 3'b000;
            buf0 <= '0;
            buf1 <= '0;
            buf2 <= '0;
        end else begin
            if (req0) begin
                pend[0] <= 1'b1;
                buf0    <= data0;
            end else if (launch && (win == 2'd0)) begin
                pend[0] <= 1'b0;
            end
            if (req1) begin
                pend[1] <= 1'b1;
                buf1    <= data1;
            end else if (launch && (win == 2'd1)) begin
                pend[1] <= 1'b0;
            end
            if (req2) begin
                pend[2] <= 1'b1;
                buf2    <= data2;
            end else if (launch && (win == 2'd2)) begin
                pend[2] <= 1'b0;
            end
        end
    end

    // Scheduler FSM with registered engine inputs; reset loads the longest
    // hold-off so a packet cut short by reset still drains from the engine.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= s_idle;
            holdoff  <= hold_max;
            rr       <= 1'b0;
            slot     <= 2'd0;
            send     <= 1'b0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            ack2     <= 1'b0;
            address  <= '0;
            data_len <= '0;
            value1   <= '0;
            value2   <= '0;
            value3   <= '0;
            value4   <= '0;
        end else begin
            send <= 1'b0;
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            ack2 <= 1'b0;
            case (state)
                s_idle: begin
                    if (holdoff != 24'd0) begin
                        holdoff <= holdoff - 24'd1;
                    end else if (launch) begin
                        state    <= s_issue;
                        send     <= 1'b1;
                        ack0     <= (win == 2'd0);
                        ack1     <= (win == 2'd1);
                        ack2     <= (win == 2'd2);
                        slot     <= win;
                        address  <= win_addr;
                        data_len <= win_len;
                        value1   <= win_buf[31:0];
                        value2   <= win_buf[63:32];
                        value3   <= win_buf[95:64];
                        value4   <= win_buf[127:96];
                        if (win != 2'd0) begin
                            rr <= ~rr;
                        end
                    end
                end
                s_issue: begin
                    holdoff <= hold_sel;
                    state   <= s_wait;
                end
                s_wait: begin
                    holdoff <= holdoff - 24'd1;
                    if (holdoff == 24'd1) begin
                        state <= s_idle;
                    end
                end
                default: begin
                    state <= s_idle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dynamixel_write_scheduler.sv
// Testbench for dynamixel_write_scheduler: directed scenarios plus random
// request traffic, compared every cycle against a launch-schedule model.

module tb_dynamixel_write_scheduler;

    localparam int cpb   = 2;
    localparam int guard = 2;
    localparam int gap   = 4;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         req0 = 1'b0, req1 = 1'b0, req2 = 1'b0;
    logic [127:0] data0 = '0, data1 = '0, data2 = '0;
    logic         ack0, ack1, ack2, busy, send;
    logic [15:0]  address, data_len;
    logic [31:0]  value1, value2, value3, value4;

    always #5 clock = ~clock;

    dynamixel_write_scheduler #(
        .clocks_per_bit(cpb),
        .byte_guard    (guard),
        .gap_cycles    (gap)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .req0    (req0),
        .req1    (req1),
        .req2    (req2),
        .data0   (data0),
        .data1   (data1),
        .data2   (data2),
        .ack0    (ack0),
        .ack1    (ack1),
        .ack2    (ack2),
        .busy    (busy),
        .send    (send),
        .address (address),
        .data_len(data_len),
        .value1  (value1),
        .value2  (value2),
        .value3  (value3),
        .value4  (value4)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: launch schedule, pending flags, values, held outputs.
    int           addr_t[3] = '{64, 104, 116};
    int           len_t[3]  = '{1, 4, 4};
    int           e;
    int           next_grant;
    bit   [2:0]   m_pend;
    logic [127:0] m_buf[3];
    bit           m_rr;
    logic         m_send;
    logic [2:0]   m_ack;
    logic [15:0]  m_addr, m_len;
    logic [127:0] m_val;

    // Observations recorded at each launch seen on the DUT.
    int           obs_e;
    int           obs_slot;
    logic [127:0] obs_val;
    logic [15:0]  obs_len;
    int           slot_cnt[3] = '{0, 0, 0};

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, e);
        end
    endtask

    function automatic int hold(input int len);
        return (14 + 4 * (1 + len)) * (10 * cpb + guard) + gap;
    endfunction

    function automatic void model_reset();
        e          = 0;
        next_grant = hold(4) + 1;
        m_pend     = '0;
        m_rr       = 1'b0;
        m_send     = 1'b0;
        m_ack      = '0;
        m_addr     = '0;
        m_len      = '0;
        m_val      = '0;
        for (int i = 0; i < 3; i++) m_buf[i] = '0;
    endfunction

    function automatic void model_edge();
        int w;
        e++;
        m_send = 1'b0;
        m_ack  = '0;
        if (e >= next_grant && m_pend != 3'b000) begin
            if (m_pend[0])                  w = 0;
            else if (m_pend[1] && m_pend[2]) w = m_rr ? 2 : 1;
            else                            w = m_pend[1] ? 1 : 2;
            m_send     = 1'b1;
            m_ack[w]   = 1'b1;
            m_addr     = 16'(addr_t[w]);
            m_len      = 16'(len_t[w]);
            m_val      = m_buf[w];
            m_pend[w]  = 1'b0;
            if (w != 0) m_rr = !m_rr;
            next_grant = e + hold(len_t[w]) + 2;
        end
        if (req0) begin m_pend[0] = 1'b1; m_buf[0] = data0; end
        if (req1) begin m_pend[1] = 1'b1; m_buf[1] = data1; end
        if (req2) begin m_pend[2] = 1'b1; m_buf[2] = data2; end
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic step();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check("send", send, m_send);
        check("ack", {ack2, ack1, ack0}, m_ack);
        check("busy", busy, (e + 1 < next_grant));
        check("address", address, m_addr);
        check("data_len", data_len, m_len);
        check("values", {value4, value3, value2, value1}, m_val);
        if (send) begin
            obs_e    = e;
            obs_slot = ack1 ? 1 : (ack2 ? 2 : 0);
            obs_val  = {value4, value3, value2, value1};
            obs_len  = data_len;
            slot_cnt[obs_slot]++;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        req2 = 1'b0;
    endtask

    task automatic wait_send(input int budget);
        bit got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            step();
            if (send) got = 1'b1;
        end
        check("send_timeout", got, 1'b1);
    endtask

    task automatic wait_drain(input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            if (m_pend == 3'b000 && !busy) done = 1'b1;
            else step();
        end
        check("drain_timeout", done, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_send"}, send, 1'b0);
        check({tag, "_ack"}, {ack2, ack1, ack0}, 3'b000);
        check({tag, "_busy"}, busy, 1'b1);
        check({tag, "_addr"}, address, 16'd0);
        check({tag, "_len"}, data_len, 16'd0);
        check({tag, "_vals"}, {value4, value3, value2, value1}, 128'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int           seq[5];
        int           ev[5];
        int           e0;
        int           c1;
        logic [127:0] va, vb;

        // Reset and start-up hold-off.
        repeat (3) @(negedge clock);
        check_reset_outputs("rst");
        reset_n = 1'b1;
        model_reset();

        req2  = 1'b1;
        data2 = 128'h0000_0400_0000_0300_0000_0200_0000_0100;
        step();
        wait_send(1000);
        check("t1_launch_edge", obs_e, 753);
        check("t1_slot", obs_slot, 2);
        check("t1_addr", address, 16'd116);
        check("t1_len", data_len, 16'd4);
        check("t1_vals", obs_val, 128'h0000_0400_0000_0300_0000_0200_0000_0100);
        wait_drain(2000);

        // Priority: slot 0 beats slot 1 raised in the same cycle.
        req0 = 1'b1; data0 = rnd128();
        req1 = 1'b1; data1 = rnd128();
        step();
        wait_send(10);
        check("t2_first_slot", obs_slot, 0);
        check("t2_first_len", obs_len, 16'd1);
        e0 = obs_e;
        wait_send(1000);
        check("t2_second_slot", obs_slot, 1);
        check("t2_gap", obs_e - e0, 490);
        wait_drain(2000);

        // Round-robin between slots 1 and 2 with an interposed slot 0.
        req1 = 1'b1; data1 = rnd128();
        req2 = 1'b1; data2 = rnd128();
        step();
        for (int k = 0; k < 5; k++) begin
            wait_send(1000);
            seq[k] = obs_slot;
            ev[k]  = obs_e;
            if (k < 3) begin
                if (obs_slot == 1) begin req1 = 1'b1; data1 = rnd128(); end
                if (obs_slot == 2) begin req2 = 1'b1; data2 = rnd128(); end
            end
            if (k == 1) begin req0 = 1'b1; data0 = rnd128(); end
        end
        check("t3_seq0", seq[0], 1);
        check("t3_seq1", seq[1], 2);
        check("t3_seq2", seq[2], 0);
        check("t3_seq3", seq[3], 1);
        check("t3_seq4", seq[4], 2);
        check("t3_gap01", ev[1] - ev[0], 754);
        check("t3_gap23", ev[3] - ev[2], 490);
        check("t3_gap34", ev[4] - ev[3], 754);
        wait_drain(3000);

        // Coalescing: two slot-1 requests during one WAIT give one packet.
        req2 = 1'b1; data2 = rnd128();
        step();
        wait_send(10);
        c1 = slot_cnt[1];
        repeat (10) step();
        req1 = 1'b1; data1 = 128'd10;
        step();
        repeat (10) step();
        req1 = 1'b1; data1 = 128'd20;
        step();
        wait_send(1000);
        check("t4_slot", obs_slot, 1);
        check("t4_value", obs_val, 128'd20);
        wait_drain(2000);
        check("t4_count", slot_cnt[1] - c1, 1);

        // Re-request of slot 2 during its own ISSUE cycle.
        va = rnd128();
        vb = rnd128();
        req2 = 1'b1; data2 = va;
        step();
        wait_send(10);
        check("t5_first_slot", obs_slot, 2);
        check("t5_first_val", obs_val, va);
        req2 = 1'b1; data2 = vb;
        step();
        wait_send(1000);
        check("t5_second_slot", obs_slot, 2);
        check("t5_second_val", obs_val, vb);
        wait_drain(2000);

        // Reset in the middle of WAIT drops pending work and restarts hold-off.
        req1 = 1'b1; data1 = rnd128();
        step();
        wait_send(10);
        repeat (50) step();
        req2 = 1'b1; data2 = rnd128();
        step();
        repeat (49) step();
        reset_n = 1'b0;
        #1;
        check_reset_outputs("t6_rst");
        repeat (3) @(negedge clock);
        check_reset_outputs("t6_rst_hold");
        reset_n = 1'b1;
        model_reset();
        req0 = 1'b1; data0 = rnd128();
        step();
        wait_send(1000);
        check("t6_slot", obs_slot, 0);
        check("t6_launch_edge", obs_e, 753);
        wait_drain(2000);

        // Random request traffic.
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 199) == 0) begin req0 = 1'b1; data0 = rnd128(); end
            if ($urandom_range(0, 149) == 0) begin req1 = 1'b1; data1 = rnd128(); end
            if ($urandom_range(0, 149) == 0) begin req2 = 1'b1; data2 = rnd128(); end
            step();
        end
        wait_drain(4000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
